// File: rtl/seven_seg_digit_scanner_if.sv
// seven_seg_digit_scanner_if: valid/ready value bus; the producer is master, the scanner is slave
interface seven_seg_digit_scanner_if;
  logic [15:0] value_in;
  logic [3:0]  dp_mask;
  logic        value_valid;
  logic        value_ready;
  modport master (output value_in, dp_mask, value_valid, input value_ready);
  modport slave  (input value_in, dp_mask, value_valid, output value_ready);
endinterface

// File: rtl/seven_seg_digit_scanner.sv
// seven_seg_digit_scanner: multiplexes a 4-nibble hex value onto one 7-segment decoder with frame-aligned updates
// Ports: clk/rst (sync active-high); bus = value_in/dp_mask/value_valid/value_ready (slave);
// lz_blank_en live blanking enable; digit_bin/digit_dp_en/digit_blank feed the decoder;
// anode active-low digit selects; frame_done pulses once per 4-digit frame.
module seven_seg_digit_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 2,
  parameter int CNT_W    = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  seven_seg_digit_scanner_if.slave     bus,
  input  logic                         lz_blank_en,
  output logic [3:0]                   digit_bin,
  output logic                         digit_dp_en,
  output logic                         digit_blank,
  output logic [3:0]                   anode,
  output logic                         frame_done
);
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_shadow, r_pend;
  logic [3:0]       r_sdp, r_pdp;
  logic             r_ready;
  logic             w_wrap, w_bnd, w_load, w_acc, w_dead, w_blank;
  logic [CNT_W-1:0] w_cnt_n;
  logic [1:0]       w_idx_n;
  logic [15:0]      w_shadow_n, w_upper;
  logic [3:0]       w_sdp_n;
  assign bus.value_ready = r_ready;
  assign w_wrap     = r_cnt == CNT_W'(SCAN_DIV - 1);
  assign w_cnt_n    = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_idx_n    = r_idx + {1'b0, w_wrap};
  assign w_bnd      = w_wrap && r_idx == 2'd3;
  // r_ready low means a value is waiting in the pending register
  assign w_load     = w_bnd && !r_ready;
  assign w_acc      = bus.value_valid && r_ready;
  // outputs are computed from next-state values so they change on the same edge as the counter/index
  assign w_shadow_n = w_load ? r_pend : r_shadow;
  assign w_sdp_n    = w_load ? r_pdp : r_sdp;
  assign w_upper    = w_shadow_n >> {w_idx_n, 2'b00};
  assign w_dead     = w_cnt_n < CNT_W'(DEAD_CYC);
  assign w_blank    = lz_blank_en && w_idx_n != 2'd0 && w_upper == 16'd0 && !w_sdp_n[w_idx_n];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_sdp       <= '0;
      r_pend      <= '0;
      r_pdp       <= '0;
      r_ready     <= 1'b1;
      anode       <= 4'hF;
      digit_bin   <= '0;
      digit_dp_en <= 1'b0;
      digit_blank <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_n;
      r_idx       <= w_idx_n;
      r_shadow    <= w_shadow_n;
      r_sdp       <= w_sdp_n;
      r_ready     <= w_load || (r_ready && !w_acc);
      if (w_acc) begin
        r_pend <= bus.value_in;
        r_pdp  <= bus.dp_mask;
      end
      anode       <= (w_dead || w_blank) ? 4'hF : ~(4'b0001 << w_idx_n);
      digit_bin   <= w_blank ? 4'd0 : w_upper[3:0];
      digit_dp_en <= !w_blank && w_sdp_n[w_idx_n];
      digit_blank <= w_blank;
      frame_done  <= w_bnd;
    end
  end
endmodule

// File: tb/tb_seven_seg_digit_scanner.sv
// tb_seven_seg_digit_scanner: directed plus random stimulus checked against a cycle-count based model
module tb_seven_seg_digit_scanner;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam int FR = 4 * SD;
  logic clk = 1'b0, rst = 1'b1, lz = 1'b0;
  logic [3:0] digit_bin, anode;
  logic dp_en, blank, fd;
  int n_chk = 0, n_pass = 0, cyc_n = 0;
  int t = 0;
  logic [15:0] m_sh = '0, m_pv = '0;
  logic [3:0] m_sd = '0, m_pd = '0;
  logic m_rdy = 1'b1, m_acc = 1'b0, m_fd = 1'b0;
  seven_seg_digit_scanner_if bus();
  seven_seg_digit_scanner #(.SCAN_DIV(SD), .DEAD_CYC(DC)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .lz_blank_en(lz),
    .digit_bin(digit_bin), .digit_dp_en(dp_en), .digit_blank(blank),
    .anode(anode), .frame_done(fd)
  );
  always #5 clk = ~clk;
  assert property (@(negedge clk) $countones(~anode) <= 1)
    else $error("FAIL anode_onehot anode=%b", anode);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc_n, got, exp);
  endtask
  task automatic step();
    int k, c;
    logic [15:0] up;
    logic bl;
    logic [3:0] e_an;
    @(posedge clk);
    #1;
    cyc_n++;
    m_acc = 1'b0;
    if (rst) begin
      t = 0; m_sh = '0; m_sd = '0; m_rdy = 1'b1; m_fd = 1'b0;
    end else begin
      m_fd = (t % FR) == FR - 1;
      m_acc = bus.value_valid && m_rdy;
      if (m_fd && !m_rdy) begin m_sh = m_pv; m_sd = m_pd; m_rdy = 1'b1; end
      if (m_acc) begin m_pv = bus.value_in; m_pd = bus.dp_mask; m_rdy = 1'b0; end
      t++;
    end
    k = (t / SD) % 4;
    c = t % SD;
    up = m_sh >> (4 * k);
    bl = lz && k > 0 && up == 16'd0 && !m_sd[k];
    e_an = (c < DC || bl) ? 4'hF : ~(4'b0001 << k);
    check("anode", anode, e_an);
    check("digit_bin", digit_bin, bl ? 4'd0 : up[3:0]);
    check("dp_en", dp_en, !bl && m_sd[k]);
    check("blank", blank, bl);
    check("frame_done", fd, m_fd);
    check("ready", bus.value_ready, m_rdy);
    check("anode_onehot", $countones(~anode) <= 1, 1'b1);
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic wait_phase(input int p);
    int n = 0;
    while ((t % FR) != p && n < 2 * FR) begin step(); n++; end
    check("wait_phase", t % FR, p);
  endtask
  task automatic send(input logic [15:0] v, input logic [3:0] d);
    int n = 0;
    bus.value_valid = 1'b1; bus.value_in = v; bus.dp_mask = d;
    do begin step(); n++; end while (!m_acc && n < 3 * FR);
    check("send_accepted", m_acc, 1'b1);
    bus.value_valid = 1'b0;
  endtask
  initial begin
    logic [15:0] msk;
    bus.value_valid = 1'b0; bus.value_in = '0; bus.dp_mask = '0;
    rst = 1'b1; run(2); rst = 1'b0;
    run(FR + 2);
    send(16'h1234, 4'b0100);
    wait_phase(FR - 1); run(FR + 1);
    lz = 1'b1;
    send(16'h0050, 4'b0000);
    wait_phase(FR - 1); run(FR);
    wait_phase(12); lz = 1'b0; run(FR);
    send(16'hAAAA, 4'b0000);
    send(16'hBBBB, 4'b1010);
    run(2 * FR);
    wait_phase(FR - 1); step();
    send(16'hC3C3, 4'b0101);
    wait_phase(21);
    rst = 1'b1; step(); rst = 1'b0;
    run(FR + 4);
    run(5 * FR);
    repeat (1500) begin
      if (!bus.value_valid && $urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: msk = 16'hFFFF;
          1: msk = 16'h00FF;
          2: msk = 16'h000F;
          default: msk = 16'h0F0F;
        endcase
        bus.value_valid = 1'b1;
        bus.value_in = 16'($urandom) & msk;
        bus.dp_mask = $urandom_range(1) ? 4'($urandom) : 4'd0;
      end
      if ($urandom_range(40) == 0) lz = ~lz;
      rst = $urandom_range(400) == 0;
      step();
      if (m_acc) bus.value_valid = 1'b0;
    end
    rst = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seven_seg_digit_scanner.md
Name: seven_seg_digit_scanner

Overview:
- Upstream stage for the single-digit seven_segement decoder.
- Accepts a 16-bit hex value (4 nibbles) plus per-digit decimal-point mask through a valid/ready handshake.
- Time-multiplexes the four digits onto one decoder: drives the digit nibble, dp enable, blank flag and active-low anode selects.
- Latched values take effect only at frame boundaries, so a scan frame never mixes old and new digits.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; legal range ≥ 4.
- DEAD_CYC, 2: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 to SCAN_DIV-2.
- CNT_W, 24: width of the slot counter; must satisfy 2^CNT_W > SCAN_DIV.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- value_in  input  16  hex value; nibble k shown on digit k (digit 0 = rightmost, LS nibble)
- dp_mask  input  4  per-digit dp enable; captured with value_in
- value_valid  input  1  value_in/dp_mask valid
- value_ready  output  1  block can accept a value
- lz_blank_en  input  1  leading-zero blanking enable; sampled live, not shadowed
- digit_bin  output  4  nibble for the decoder's bin_in
- digit_dp_en  output  1  to the decoder's dp_en
- digit_blank  output  1  current digit blanked by leading-zero logic
- anode  output  4  active-low digit enables; at most one bit low
- frame_done  output  1  one-cycle pulse per completed 4-digit frame

Behaviour:
- Every function in this block uses one clock and a synchronous, active-high reset. The ports are named clk and rst.
- All outputs are registered.
- Reset state (the edge with rst=1):
  - slot counter = 0, digit_idx = 0
  - shadow value = 0, shadow dp = 0, pending register cleared
  - anode = 4'b1111, digit_bin = 0, digit_dp_en = 0, digit_blank = 0
  - frame_done = 0, value_ready = 1
- Reset during any slot or with a pending value discards the pending value. Scanning restarts at digit 0 with its dead time.
- Slot counter: counts 0 to SCAN_DIV-1, then wraps to 0. At each wrap, digit_idx advances 0→1→2→3→0.
- Output timing: outputs for a slot become valid on the same edge on which the counter or index takes its new value.
- Anode control:
  - Counter < DEAD_CYC: anode = 4'b1111.
  - Otherwise: anode[digit_idx] = 0 unless the digit is blanked.
- Digit data: digit_bin = shadow nibble[digit_idx], digit_dp_en = shadow_dp[digit_idx]. Both hold for the whole slot, including dead time.
- Leading-zero blanking: applies when lz_blank_en=1 and digit_idx = k ≥ 1, shadow nibbles k..3 are all 0, and shadow_dp[k] = 0. Then:
  - digit_blank = 1, digit_bin = 0, digit_dp_en = 0
  - anode stays 4'b1111 for that slot
  - Digit 0 is never blanked.
- Handshake:
  - Transfer occurs on an edge where value_valid && value_ready. value_in and dp_mask go into the pending register, and value_ready drops to 0 on that edge.
  - Frame boundary = the edge where digit_idx wraps 3→0. If a value is pending, it moves to the shadow there and value_ready returns to 1 on the same edge.
  - A transfer on the boundary edge itself goes to pending, not to the shadow. It is shown from the following boundary.
  - value_valid while value_ready=0 is ignored; the producer holds it.
- frame_done = 1 for exactly the cycle following each frame boundary edge. Period = 4*SCAN_DIV cycles.
- Arithmetic:
  - Slot counter is CNT_W bits unsigned; compare against SCAN_DIV-1.
  - digit_idx is 2 bits and wraps naturally.

Test Plan (SCAN_DIV=8, DEAD_CYC=2):
1. Reset for 2 cycles, then release → anode=1111 for 2 cycles, then 1110 for 6 cycles with digit_bin=0. value_ready=1. First frame_done arrives 32 cycles after the first counted cycle.
2. Send 16'h1234 with dp_mask=4'b0100 at idle → value_ready=0 until the next boundary. The following frame shows digit_bin 4,3,2,1 on anodes 1110, 1101, 1011, 0111. digit_dp_en=1 only on idx 2.
3. Send 16'h0050, dp_mask=0, lz_blank_en=1 → idx 3 and idx 2 have digit_blank=1 and anode=1111. idx 1 shows 5, idx 0 shows 0. Toggle lz_blank_en=0 mid-frame → later slots of that frame show 0, not blanked.
4. Hold value_valid with A=16'hAAAA, then B=16'hBBBB → A is accepted and ready stays low until the boundary. B is accepted on or after that edge and appears one frame later. No frame ever mixes A and B nibbles.
5. Assert rst at idx 2, counter 5, with a value pending → next cycle idx=0, counter=0, anode=1111, value_ready=1. The shadow shows 0; the pending value never appears.
6. Run 5 frames → frame_done pulses exactly every 32 cycles, each 1 cycle wide. At most one anode bit is low in any cycle (assertion).
